// File: rtl/api_chain_ctrl_pkg.sv
// API chain controller shared definitions.
// State encodings and default sizing for the chain controller.
package api_chain_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WORK  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int API_NUM_D       = 16;
    localparam int WORK_WORDS_D    = 23;
    localparam int RX_WORDS_D      = 4;
    localparam int NONCE_WORD_D    = 2;
    localparam int RX_FIFO_DEPTH_D = 256;
    localparam int TMR_W           = 25;

endpackage

// File: rtl/api_chain_ctrl_timer.sv
// Frame timer: loadable down-counter.
// Busy while non-zero; expired flags the last counted cycle.
module api_chain_ctrl_timer
    import api_chain_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TMR_W-1:0] load_val,
    output logic             busy,
    output logic             expired
);

    logic [TMR_W-1:0] cnt_q;

    // Load on start, then count down to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign busy    = (cnt_q != '0);
    assign expired = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/api_chain_ctrl.sv
// API chain controller: fetches work packets, broadcasts them
// down each enabled chip chain and captures tagged results.
module api_chain_ctrl
    import api_chain_ctrl_pkg::*;
#(
    parameter int API_NUM       = API_NUM_D,
    parameter int WORK_WORDS    = WORK_WORDS_D,
    parameter int RX_WORDS      = RX_WORDS_D,
    parameter int NONCE_WORD    = NONCE_WORD_D,
    parameter int RX_FIFO_DEPTH = RX_FIFO_DEPTH_D,
    parameter int CH_W          = $clog2(API_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [API_NUM-1:0] reg_ch_mask,
    input  logic [5:0]         reg_chip_num,
    input  logic [31:0]        reg_nonce_step,
    input  logic [7:0]         reg_sck,
    input  logic [24:0]        reg_timeout,
    input  logic               reg_abort,
    output logic [2:0]         reg_state,
    output logic               err_timeout,
    input  logic               tx_fifo_empty,
    output logic               tx_fifo_rd_en,
    input  logic [31:0]        tx_fifo_dout,
    output logic               rx_fifo_wr_en,
    output logic [31:0]        rx_fifo_din,
    output logic [CH_W+5:0]    rx_fifo_tag,
    input  logic [8:0]         rx_fifo_data_count,
    output logic               phy_mosi_vld,
    output logic [31:0]        phy_mosi_dat,
    input  logic               phy_miso_vld,
    input  logic [31:0]        phy_miso_dat,
    output logic               phy_miso,
    output logic [API_NUM-1:0] load,
    input  logic [API_NUM-1:0] miso
);

    localparam int IDX_W = $clog2(WORK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] WW_C    = CNT_W'(WORK_WORDS);
    localparam logic [CNT_W-1:0] WW_LAST = CNT_W'(WORK_WORDS - 1);
    localparam logic [CNT_W-1:0] RX_C    = CNT_W'(RX_WORDS);
    localparam logic [CNT_W-1:0] NONCE_C = CNT_W'(NONCE_WORD);
    localparam logic [8:0] RX_LIM = 9'(RX_FIFO_DEPTH - RX_WORDS - 1);

    // Lowest enabled channel at or above 'from'; MSB is the found flag.
    function automatic logic [CH_W:0] find_ch(
        input logic [API_NUM-1:0] m,
        input logic [CH_W:0]      from
    );
        logic [CH_W:0] r;
        r = '0;
        for (int i = API_NUM - 1; i >= 0; i--) begin
            if (m[i] && ((CH_W+1)'(i) >= from)) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    logic [2:0]         state_q;
    logic [CH_W-1:0]    ch_idx_q;
    logic [5:0]         chip_cnt_q;
    logic [CNT_W-1:0]   pop_cnt_q;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               rd_pend_q;
    logic               rx_en_q;
    logic [1:0]         ld_ph_q;
    logic [9:0]         wait_q;
    logic [API_NUM-1:0] load_q;
    logic               mosi_vld_q;
    logic               err_q;
    logic               wr_en_q;
    logic [31:0]        din_q;
    logic [CH_W+5:0]    tag_q;
    logic [31:0]        wbuf_q [WORK_WORDS];

    logic          tmr_busy;
    logic          tmr_expired;
    logic          tmr_start;
    logic          active;
    logic          abort_now;
    logic          tmo_now;
    logic          kill;
    logic          go;
    logic          last_word;
    logic          chip_last;
    logic          rx_ok;
    logic [CH_W:0] first;
    logic [CH_W:0] nxt;

    assign active    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign abort_now = reg_abort & active;
    assign tmo_now   = tmr_expired & active;
    assign kill      = abort_now | tmo_now;
    assign first     = find_ch(reg_ch_mask, '0);
    assign nxt       = find_ch(reg_ch_mask,
                               {1'b0, ch_idx_q} + (CH_W+1)'(1));
    assign go        = ~tx_fifo_empty & first[CH_W] & (|reg_chip_num);
    assign tmr_start = (state_q == ST_IDLE) & go;
    assign last_word = phy_miso_vld && (word_cnt_q == WW_LAST);
    assign chip_last = ((chip_cnt_q + 6'd1) == reg_chip_num);
    assign rx_ok     = (rx_fifo_data_count <= RX_LIM);

    assign tx_fifo_rd_en = (state_q == ST_FETCH) & ~tx_fifo_empty &
                           (pop_cnt_q < WW_C) & ~kill;
    assign phy_mosi_vld  = mosi_vld_q & ~kill;
    assign phy_mosi_dat  = (state_q == ST_WORK) ?
                           wbuf_q[word_cnt_q[IDX_W-1:0]] : '0;
    assign phy_miso      = &(miso | load_q);
    assign load          = load_q;
    assign reg_state     = state_q;
    assign err_timeout   = err_q;
    assign rx_fifo_wr_en = wr_en_q;
    assign rx_fifo_din   = din_q;
    assign rx_fifo_tag   = tag_q;

    api_chain_ctrl_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .load_val (reg_timeout),
        .busy     (tmr_busy),
        .expired  (tmr_expired)
    );

    // Frame sequencing: fetch, per-chip broadcast, latch, channel walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_idx_q   <= '0;
            chip_cnt_q <= '0;
            pop_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            word_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rx_en_q    <= 1'b0;
            ld_ph_q    <= '0;
            wait_q     <= '0;
            load_q     <= '1;
            mosi_vld_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
            tag_q      <= '0;
        end else begin
            mosi_vld_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_pend_q  <= tx_fifo_rd_en;
            if (kill) begin
                state_q <= ST_DONE;
                load_q  <= '1;
                err_q   <= tmo_now;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (go) begin
                            state_q    <= ST_FETCH;
                            ch_idx_q   <= first[CH_W-1:0];
                            load_q     <= ~(API_NUM'(1) << first[CH_W-1:0]);
                            chip_cnt_q <= '0;
                            pop_cnt_q  <= '0;
                            wr_cnt_q   <= '0;
                            word_cnt_q <= '0;
                        end
                    end
                    ST_FETCH: begin
                        if (tx_fifo_rd_en) begin
                            pop_cnt_q <= pop_cnt_q + CNT_W'(1);
                        end
                        if (rd_pend_q) begin
                            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                            if (wr_cnt_q == WW_LAST) begin
                                state_q    <= ST_WORK;
                                mosi_vld_q <= 1'b1;
                                rx_en_q    <= rx_ok;
                                word_cnt_q <= '0;
                            end
                        end
                    end
                    ST_WORK: begin
                        if (phy_miso_vld) begin
                            if (rx_en_q && (word_cnt_q < RX_C)) begin
                                wr_en_q <= 1'b1;
                                din_q   <= phy_miso_dat;
                                tag_q   <= {ch_idx_q, chip_cnt_q};
                            end
                            if (last_word) begin
                                word_cnt_q <= '0;
                                chip_cnt_q <= chip_cnt_q + 6'd1;
                                if (chip_last) begin
                                    state_q <= ST_LOAD;
                                    wait_q  <= {reg_sck, 2'b00};
                                    ld_ph_q <= 2'd0;
                                end else begin
                                    mosi_vld_q <= 1'b1;
                                    rx_en_q    <= rx_ok;
                                end
                            end else begin
                                word_cnt_q <= word_cnt_q + CNT_W'(1);
                                mosi_vld_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        unique case (ld_ph_q)
                            2'd0: begin
                                if (wait_q != '0) begin
                                    wait_q <= wait_q - 10'd1;
                                end else begin
                                    mosi_vld_q <= 1'b1;
                                    ld_ph_q    <= 2'd1;
                                end
                            end
                            2'd1: begin
                                if (phy_miso_vld) begin
                                    wait_q  <= {1'b0, reg_sck, 1'b0};
                                    ld_ph_q <= 2'd2;
                                end
                            end
                            default: begin
                                if (wait_q != '0) begin
                                    wait_q <= wait_q - 10'd1;
                                end else begin
                                    load_q  <= '1;
                                    state_q <= ST_NEXT;
                                end
                            end
                        endcase
                    end
                    ST_NEXT: begin
                        if (nxt[CH_W]) begin
                            state_q    <= ST_FETCH;
                            ch_idx_q   <= nxt[CH_W-1:0];
                            load_q     <= ~(API_NUM'(1) << nxt[CH_W-1:0]);
                            chip_cnt_q <= '0;
                            pop_cnt_q  <= '0;
                            wr_cnt_q   <= '0;
                            word_cnt_q <= '0;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (!tmr_busy) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Packet buffer: filled from the TX FIFO, nonce word bumped per chip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORK_WORDS; i++) begin
                wbuf_q[i] <= '0;
            end
        end else if (!kill) begin
            if ((state_q == ST_FETCH) && rd_pend_q) begin
                wbuf_q[wr_cnt_q[IDX_W-1:0]] <= tx_fifo_dout;
            end
            if ((state_q == ST_WORK) && phy_miso_vld &&
                (word_cnt_q == NONCE_C)) begin
                wbuf_q[NONCE_WORD] <= wbuf_q[NONCE_WORD] + reg_nonce_step;
            end
        end
    end

endmodule

// File: tb/tb_api_chain_ctrl.sv
// Bench for api_chain_ctrl: FIFO and PHY models, vector table
// and directed multi-cycle sequences.
module tb_api_chain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] reg_ch_mask = '0;
    logic [5:0]  reg_chip_num = '0;
    logic [31:0] reg_nonce_step = 32'd1;
    logic [7:0]  reg_sck = 8'd2;
    logic [24:0] reg_timeout = '0;
    logic        reg_abort = 1'b0;
    logic [2:0]  reg_state;
    logic        err_timeout;
    logic        tx_fifo_empty = 1'b1;
    logic        tx_fifo_rd_en;
    logic [31:0] tx_fifo_dout = '0;
    logic        rx_fifo_wr_en;
    logic [31:0] rx_fifo_din;
    logic [9:0]  rx_fifo_tag;
    logic [8:0]  rx_fifo_data_count = '0;
    logic        phy_mosi_vld;
    logic [31:0] phy_mosi_dat;
    logic        phy_miso_vld = 1'b0;
    logic [31:0] phy_miso_dat = '0;
    logic        phy_miso;
    logic [15:0] load;
    logic [15:0] miso = '0;

    api_chain_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .reg_ch_mask(reg_ch_mask), .reg_chip_num(reg_chip_num),
        .reg_nonce_step(reg_nonce_step), .reg_sck(reg_sck),
        .reg_timeout(reg_timeout), .reg_abort(reg_abort),
        .reg_state(reg_state), .err_timeout(err_timeout),
        .tx_fifo_empty(tx_fifo_empty), .tx_fifo_rd_en(tx_fifo_rd_en),
        .tx_fifo_dout(tx_fifo_dout), .rx_fifo_wr_en(rx_fifo_wr_en),
        .rx_fifo_din(rx_fifo_din), .rx_fifo_tag(rx_fifo_tag),
        .rx_fifo_data_count(rx_fifo_data_count),
        .phy_mosi_vld(phy_mosi_vld), .phy_mosi_dat(phy_mosi_dat),
        .phy_miso_vld(phy_miso_vld), .phy_miso_dat(phy_miso_dat),
        .phy_miso(phy_miso), .load(load), .miso(miso)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] txq[$];
    int pop_cyc[$];
    int pops = 0, stall_at = -1, stall_left = 0, under = 0;
    bit pend = 1'b0;

    logic [31:0] mosi_w[$];
    logic [15:0] mosi_ld[$];
    int mosi_cyc[$];
    int phy_cd = 0, rx_pat = 0;
    bit phy_on = 1'b1;

    logic [31:0] rx_d[$];
    logic [9:0]  rx_t[$];
    int n_err_t = 0, err_cyc = 0, fetch_cyc = 0, idle_cyc = 0;
    logic [2:0]  err_state = '0, prev_state = '0;
    logic [15:0] err_load = '0;

    // TX FIFO model: pop data appears the cycle after rd_en.
    initial forever begin
        @(negedge clk);
        #1;
        if (stall_left > 0) stall_left--;
        if (pend) begin
            if (txq.size() > 0) tx_fifo_dout = txq.pop_front();
            pops++;
            pop_cyc.push_back(cyc);
            if (pops == stall_at) stall_left = 50;
        end
        tx_fifo_empty = (txq.size() == 0) || (stall_left > 0);
        #1;
        pend = tx_fifo_rd_en;
        if (tx_fifo_rd_en && tx_fifo_empty) under++;
    end

    // PHY model: answers each request three cycles later.
    initial forever begin
        @(negedge clk);
        #1;
        phy_miso_vld = 1'b0;
        if (phy_cd > 0) begin
            phy_cd--;
            if (phy_cd == 0) begin
                phy_miso_vld = 1'b1;
                phy_miso_dat = 32'h5000_0000 + rx_pat;
                rx_pat++;
            end
        end
        if (phy_mosi_vld) begin
            mosi_w.push_back(phy_mosi_dat);
            mosi_ld.push_back(load);
            mosi_cyc.push_back(cyc);
            if (phy_on) phy_cd = 3;
        end
    end

    // Output monitor.
    initial forever begin
        @(negedge clk);
        #2;
        if (rx_fifo_wr_en) begin
            rx_d.push_back(rx_fifo_din);
            rx_t.push_back(rx_fifo_tag);
        end
        if (err_timeout) begin
            n_err_t++;
            err_cyc = cyc;
            err_state = reg_state;
            err_load = load;
        end
        if (prev_state == 3'd0 && reg_state == 3'd1) fetch_cyc = cyc;
        if (prev_state != 3'd0 && reg_state == 3'd0) idle_cyc = cyc;
        prev_state = reg_state;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr_logs();
        mosi_w.delete(); mosi_ld.delete(); mosi_cyc.delete();
        rx_d.delete(); rx_t.delete(); pop_cyc.delete();
        pops = 0; under = 0; n_err_t = 0; rx_pat = 0;
    endtask

    task automatic push_pkt(input int p);
        for (int w = 0; w < 23; w++) txq.push_back(32'hA000_0000 + p * 256 + w);
    endtask

    task automatic wait_frame(input int maxc, output bit ok);
        int n;
        bit started;
        n = 0;
        started = 1'b0;
        while (reg_state == 3'd0 && n < 20) begin @(negedge clk); n++; end
        started = (reg_state != 3'd0);
        while (reg_state != 3'd0 && n < maxc) begin @(negedge clk); n++; end
        ok = started && (reg_state == 3'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_mosi(input int cnt, output bit ok);
        int n;
        n = 0;
        while (mosi_w.size() < cnt && n < 1000) begin @(negedge clk); n++; end
        ok = (mosi_w.size() >= cnt);
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [5:0]  chips;
        int nq;
        int pops;
        int nmosi;
        int npush;
        logic [15:0] ld0;
    } row_t;

    row_t rows[5];

    initial begin
        bit ok;
        int j, n_at;
        logic [31:0] ew;
        logic [15:0] el;

        rows[0] = '{16'h0000, 6'd2, 1, 0, 0, 0, 16'hFFFF};
        rows[1] = '{16'h0005, 6'd0, 1, 0, 0, 0, 16'hFFFF};
        rows[2] = '{16'h8000, 6'd1, 1, 23, 24, 4, 16'h7FFF};
        rows[3] = '{16'h0006, 6'd3, 2, 46, 140, 24, 16'hFFFD};
        rows[4] = '{16'h0005, 6'd2, 0, 0, 0, 0, 16'hFFFF};

        repeat (3) @(negedge clk);
        chk("rst_state", 64'(reg_state), 64'd0);
        chk("rst_load", 64'(load), 64'hFFFF);
        chk("rst_rd_en", 64'(tx_fifo_rd_en), 64'd0);
        chk("rst_mosi", 64'({phy_mosi_vld, phy_mosi_dat}), 64'd0);
        chk("rst_rx", 64'({rx_fifo_wr_en, rx_fifo_din, rx_fifo_tag}), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            clr_logs();
            for (int p = 0; p < rows[r].nq; p++) push_pkt(p);
            reg_ch_mask = rows[r].mask;
            reg_chip_num = rows[r].chips;
            if (rows[r].pops == 0) begin
                repeat (30) @(negedge clk);
            end else begin
                wait_frame(5000, ok);
                chk($sformatf("row%0d_done", r), 64'(ok), 64'd1);
            end
            chk($sformatf("row%0d_state", r), 64'(reg_state), 64'd0);
            chk($sformatf("row%0d_pops", r), 64'(pops), 64'(rows[r].pops));
            chk($sformatf("row%0d_mosi", r), 64'(mosi_w.size()), 64'(rows[r].nmosi));
            chk($sformatf("row%0d_push", r), 64'(rx_d.size()), 64'(rows[r].npush));
            chk($sformatf("row%0d_ld0", r),
                64'(mosi_ld.size() > 0 ? mosi_ld[0] : 16'hFFFF), 64'(rows[r].ld0));
            txq.delete();
            reg_ch_mask = '0;
            reg_chip_num = '0;
            repeat (5) @(negedge clk);
        end

        // Two channels, two chips: words, nonce, load and tags.
        clr_logs();
        push_pkt(0);
        push_pkt(1);
        reg_ch_mask = 16'h0005;
        reg_chip_num = 6'd2;
        wait_frame(5000, ok);
        chk("main_done", 64'(ok), 64'd1);
        chk("main_mosi_n", 64'(mosi_w.size()), 64'd94);
        chk("main_push_n", 64'(rx_d.size()), 64'd16);
        j = 0;
        for (int k = 0; k < 2; k++) begin
            el = (k == 0) ? 16'hFFFE : 16'hFFFB;
            for (int c = 0; c < 3; c++) begin
                for (int w = 0; w < ((c < 2) ? 23 : 1); w++) begin
                    ew = (c == 2) ? 32'd0 :
                         32'hA000_0000 + k * 256 + w + ((w == 2) ? c : 0);
                    if (j < mosi_w.size()) begin
                        chk($sformatf("main_w%0d", j), 64'(mosi_w[j]), 64'(ew));
                        chk($sformatf("main_ld%0d", j), 64'(mosi_ld[j]), 64'(el));
                    end
                    j++;
                end
            end
        end
        j = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                for (int w = 0; w < 4; w++) begin
                    if (j < rx_d.size()) begin
                        chk($sformatf("main_din%0d", j), 64'(rx_d[j]),
                            64'(32'h5000_0000 + k * 47 + c * 23 + w));
                        chk($sformatf("main_tag%0d", j), 64'(rx_t[j]),
                            64'({4'(2 * k), 6'(c)}));
                    end
                    j++;
                end
            end
        end
        reg_ch_mask = '0;
        repeat (5) @(negedge clk);

        // TX FIFO stalls after ten words.
        clr_logs();
        stall_at = 10;
        push_pkt(3);
        reg_ch_mask = 16'h0001;
        reg_chip_num = 6'd1;
        wait_frame(5000, ok);
        stall_at = -1;
        chk("stall_done", 64'(ok), 64'd1);
        chk("stall_pops", 64'(pops), 64'd23);
        chk("stall_under", 64'(under), 64'd0);
        if (pop_cyc.size() == 23 && mosi_cyc.size() > 0) begin
            chk("stall_gap", 64'(pop_cyc[10] - pop_cyc[9] >= 50), 64'd1);
            chk("stall_work", 64'(mosi_cyc[0] > pop_cyc[22]), 64'd1);
        end else begin
            chk("stall_logs", 64'(pop_cyc.size()), 64'd23);
        end
        reg_ch_mask = '0;
        repeat (5) @(negedge clk);

        // RX FIFO nearly full at the first chip, wrap-around nonce step.
        clr_logs();
        rx_fifo_data_count = 9'd252;
        reg_nonce_step = 32'hFFFF_FFFF;
        push_pkt(0);
        reg_ch_mask = 16'h0001;
        reg_chip_num = 6'd2;
        wait_mosi(1, ok);
        chk("rxf_start", 64'(ok), 64'd1);
        rx_fifo_data_count = 9'd251;
        wait_frame(5000, ok);
        chk("rxf_done", 64'(ok), 64'd1);
        chk("rxf_push", 64'(rx_d.size()), 64'd4);
        for (int i = 0; i < rx_d.size(); i++)
            chk($sformatf("rxf_tag%0d", i), 64'(rx_t[i]), 64'h001);
        if (mosi_w.size() > 25)
            chk("rxf_wrap", 64'(mosi_w[25]), 64'h A000_0001);
        else
            chk("rxf_mosi_n", 64'(mosi_w.size()), 64'd47);
        rx_fifo_data_count = '0;
        reg_nonce_step = 32'd1;
        reg_ch_mask = '0;
        repeat (5) @(negedge clk);

        // Timeout with a silent PHY.
        clr_logs();
        phy_on = 1'b0;
        reg_timeout = 25'd500;
        push_pkt(0);
        reg_ch_mask = 16'h0001;
        reg_chip_num = 6'd1;
        wait_frame(2000, ok);
        chk("tmo_idle", 64'(ok), 64'd1);
        chk("tmo_pulses", 64'(n_err_t), 64'd1);
        chk("tmo_cycle", 64'(err_cyc - fetch_cyc), 64'd500);
        chk("tmo_load", 64'(err_load), 64'hFFFF);
        chk("tmo_state", 64'(err_state), 64'd5);
        phy_on = 1'b1;
        reg_ch_mask = '0;
        repeat (10) @(negedge clk);

        // Abort in the middle of WORK.
        clr_logs();
        reg_timeout = 25'd2000;
        push_pkt(0);
        reg_ch_mask = 16'h0001;
        reg_chip_num = 6'd1;
        wait_mosi(5, ok);
        chk("abt_mid", 64'(ok && reg_state == 3'd2), 64'd1);
        reg_abort = 1'b1;
        @(negedge clk);
        reg_abort = 1'b0;
        chk("abt_done", 64'(reg_state), 64'd5);
        chk("abt_load", 64'(load), 64'hFFFF);
        n_at = mosi_w.size();
        wait_frame(3000, ok);
        chk("abt_idle", 64'(reg_state), 64'd0);
        chk("abt_no_mosi", 64'(mosi_w.size()), 64'(n_at));
        chk("abt_no_err", 64'(n_err_t), 64'd0);
        chk("abt_timer", 64'((idle_cyc - fetch_cyc >= 2000) &&
                             (idle_cyc - fetch_cyc <= 2002)), 64'd1);
        reg_ch_mask = '0;
        reg_timeout = '0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/api_chain_ctrl.md
Name: api_chain_ctrl

Overview:
- Parametrised next-generation API chain controller.
- Fetches one work packet per channel from the TX FIFO, broadcasts it down a daisy chain of reg_chip_num chips on each enabled channel, increments a configurable nonce word per chip, and captures tagged results into the RX FIFO.
- Adds over the previous generation: channel enable mask, abort, timeout error, TX-underflow stall, result tagging and an external PHY handshake.
- Sits between the register/FIFO layer and api_phy.

Parameters:
- API_NUM, 16, number of channels (load/miso width); >= 2.
- WORK_WORDS, 23, 32-bit words per work packet.
- RX_WORDS, 4, result words captured per chip; must be < WORK_WORDS.
- NONCE_WORD, 2, word index incremented per chip.
- RX_FIFO_DEPTH, 256, RX FIFO depth in words.
- CH_W, $clog2(API_NUM), channel index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_ch_mask  in  API_NUM  enabled channels.
- reg_chip_num  in  6  chips per chain.
- reg_nonce_step  in  32  added to word NONCE_WORD per chip.
- reg_sck  in  8  sck half-period in clk cycles.
- reg_timeout  in  25  frame timeout in clk cycles.
- reg_abort  in  1  level; abort current frame.
- reg_state  out  3  current FSM state.
- err_timeout  out  1  one-cycle pulse on timeout.
- tx_fifo_empty  in  1  TX FIFO empty.
- tx_fifo_rd_en  out  1  TX FIFO pop; data valid next cycle.
- tx_fifo_dout  in  32  TX FIFO data.
- rx_fifo_wr_en  out  1  RX FIFO push.
- rx_fifo_din  out  32  result word.
- rx_fifo_tag  out  CH_W+6  {channel, chip index} of the result.
- rx_fifo_data_count  in  9  RX FIFO occupancy.
- phy_mosi_vld  out  1  one-cycle request to shift out phy_mosi_dat.
- phy_mosi_dat  out  32  word to shift.
- phy_miso_vld  in  1  one-cycle: word shift complete.
- phy_miso_dat  in  32  received word.
- phy_miso  out  1  &(miso | load), to PHY.
- load  out  API_NUM  active-low channel select.
- miso  in  API_NUM  per-channel serial input.

Behaviour:
- Reset values:
  - all outputs 0 except load, which is all ones.
  - FSM IDLE; counters 0.
- States: IDLE=0, FETCH=1, WORK=2, LOAD=3, NEXT=4, DONE=5.
- IDLE -> FETCH when ~tx_fifo_empty && |reg_ch_mask && |reg_chip_num.
  - ch_idx <= lowest set bit of the mask.
  - load[ch_idx] <= 0; timer starts.
- FETCH:
  - tx_fifo_rd_en asserted only when ~tx_fifo_empty and fewer than WORK_WORDS pops are issued; an empty FIFO stalls the fetch, with no underflow.
  - Each popped word is written to an internal WORK_WORDS-entry buffer one cycle later.
  - -> WORK once all WORK_WORDS words are written.
- WORK, per chip:
  - phy_mosi_vld pulses on WORK entry and again after each phy_miso_vld until WORK_WORDS words have been sent.
  - phy_mosi_dat = buf[word_cnt].
  - Each sent word is written back to the buffer; word NONCE_WORD is written back as +reg_nonce_step (mod 2^32).
- RX capture:
  - rx enable is latched at chip start iff rx_fifo_data_count <= RX_FIFO_DEPTH-RX_WORDS-1.
  - When enabled, the first RX_WORDS phy_miso_vld of the chip push phy_miso_dat with tag {ch_idx, chip_cnt}.
  - When not enabled, the chip's results are dropped silently.
- On the WORK_WORDS-th phy_miso_vld: chip_cnt++.
  - If chip_cnt+1 == reg_chip_num -> LOAD.
  - Otherwise next chip starts the following cycle.
- LOAD:
  - Wait 4*reg_sck cycles, then one phy_mosi_vld with phy_mosi_dat = 0 (latch frame).
  - After its phy_miso_vld, wait 2*reg_sck cycles; then load <= all ones and -> NEXT.
- NEXT (1 cycle):
  - Next enabled channel above ch_idx, if one exists: load[it] <= 0, chip_cnt <= 0, -> FETCH.
  - Otherwise -> DONE.
- DONE: -> IDLE when the timer has expired; the timer expiring in DONE is not an error.
- Timeout:
  - Timer reaching reg_timeout in FETCH/WORK/LOAD/NEXT: err_timeout pulse, load all ones, -> DONE, then IDLE next cycle.
  - reg_timeout = 0 disables the timeout.
- Abort:
  - reg_abort high in any non-IDLE state except DONE: -> DONE next cycle.
  - phy_mosi_vld and tx_fifo_rd_en suppressed in that cycle; load all ones.
  - Packets already popped are discarded.
- Simultaneous abort and timeout: both take effect and err_timeout pulses.
- The mask and chip_num are sampled continuously; software changes them only in IDLE.

Decomposition:
- api_define.v: state encodings, API_NUM default, WORK_WORDS/RX_WORDS/NONCE_WORD defaults.
- Sub-module api_timer: 25-bit down-counter with start/busy/expired; reused for the timeout.
- api_phy stays external.

Test Plan:
- Mask=16'h0005, chip_num=2, step=1, two 23-word packets queued:
  - ch0 then ch2 served; load = 16'hFFFE during ch0, 16'hFFFB during ch2.
  - Word 2 sent as N then N+1 per channel.
  - 16 RX pushes, tags {0,0},{0,1},{2,0},{2,1}.
- TX FIFO empties after word 10 for 50 cycles: tx_fifo_rd_en stays low, no underflow; WORK starts only after word 23 is buffered.
- rx_fifo_data_count=252 at chip start: that chip pushes 0 words and the next chip captures normally once the count is <= 251.
- reg_timeout=500 with phy_miso_vld never returning: err_timeout pulses once at cycle 500, load=all ones, FSM returns to IDLE.
- reg_abort pulsed mid-WORK: DONE next cycle, no further phy_mosi_vld; after the timer expires, IDLE.
- reg_ch_mask=0 or reg_chip_num=0 with data queued: remains IDLE, tx_fifo_rd_en never asserted.
